// File: rtl/scanline_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : scanline_buffer_if
// Description : Write-side and raster-side signal bundle for scanline_buffer.
//               The master drives pixels and beam counters; the slave returns
//               the write-ready flag, the replayed pixel and the underrun count.
// Revision    : 1.0  initial release
// ============================================================================
interface scanline_buffer_if;
    logic       wr_valid;
    logic [7:0] wr_col;
    logic [4:0] wr_pixel;
    logic       wr_line_done;
    logic       wr_ready;
    logic [9:0] true_line;
    logic [9:0] true_column;
    logic [4:0] pixel_out;
    logic [7:0] underrun_cnt;

    modport master (
        output wr_valid, wr_col, wr_pixel, wr_line_done, true_line, true_column,
        input  wr_ready, pixel_out, underrun_cnt
    );

    modport slave (
        input  wr_valid, wr_col, wr_pixel, wr_line_done, true_line, true_column,
        output wr_ready, pixel_out, underrun_cnt
    );
endinterface
`default_nettype wire

// File: rtl/scanline_buffer.sv
`default_nettype none
// ============================================================================
// Module      : scanline_buffer
// Description : Ping-pong 256x5 line store. One bank is filled by the pixel
//               processor while the other is replayed with 2x2 scan doubling
//               onto the VGA raster. Banks swap at the end of each odd line.
// Revision    : 1.0  initial release
// ============================================================================
module scanline_buffer #(
    parameter logic [9:0] H_ACTIVE = 10'd512,
    parameter logic [9:0] V_ACTIVE = 10'd480,
    parameter logic [9:0] SWAP_COL = 10'd512
) (
    input  wire logic          clk,
    input  wire logic          reset,
    scanline_buffer_if.slave   bus
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       wsel;
    logic       wsel_next;
    logic [7:0] underrun;
    logic [7:0] underrun_next;
    logic       swap_event;
    logic       write_en;
    logic       active;
    logic [7:0] read_addr;
    logic [4:0] pixel_q;

    // Bank storage; contents are deliberately left unreset.
    logic [4:0] bank0 [0:255];
    logic [4:0] bank1 [0:255];

    // End of the second display of a line, only inside the visible frame.
    assign swap_event = (bus.true_column == SWAP_COL) && bus.true_line[0]
                        && (bus.true_line < V_ACTIVE);
    assign active     = (bus.true_column < H_ACTIVE) && (bus.true_line < V_ACTIVE);
    assign read_addr  = bus.true_column[8:1];

    // State register: FSM state, bank select and underrun counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FILL;
            wsel     <= 1'b0;
            underrun <= 8'd0;
        end else begin
            state    <= state_next;
            wsel     <= wsel_next;
            underrun <= underrun_next;
        end
    end

    // Next-state logic: line completion, swap and missed-swap accounting.
    always_comb begin
        state_next    = state;
        wsel_next     = wsel;
        underrun_next = underrun;
        case (state)
            ST_FILL: begin
                if (swap_event) begin
                    if (bus.wr_line_done) begin
                        // Line finished exactly on time: swap, keep filling.
                        wsel_next = ~wsel;
                    end else if (underrun != 8'hFF) begin
                        underrun_next = underrun + 8'd1;
                    end
                end else if (bus.wr_line_done) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (swap_event) begin
                    wsel_next  = ~wsel;
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    // Output decode: writes are accepted only while filling.
    always_comb begin
        write_en     = (state == ST_FILL) && bus.wr_valid;
        bus.wr_ready = (state == ST_FILL);
    end

    // Pixel write into the current write bank (before any toggle this edge).
    always_ff @(posedge clk) begin
        if (write_en && !wsel) bank0[bus.wr_col] <= bus.wr_pixel;
        if (write_en &&  wsel) bank1[bus.wr_col] <= bus.wr_pixel;
    end

    // Registered replay from the read bank, blanked outside the visible area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_q <= 5'd0;
        end else if (active) begin
            pixel_q <= wsel ? bank0[read_addr] : bank1[read_addr];
        end else begin
            pixel_q <= 5'd0;
        end
    end

    assign bus.pixel_out    = pixel_q;
    assign bus.underrun_cnt = underrun;

endmodule
`default_nettype wire

// File: tb/tb_scanline_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanline_buffer
// Description : Directed self-checking bench for scanline_buffer with a pixel
//               scoreboard fed from a bench-side model of both banks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scanline_buffer;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    scanline_buffer_if bus ();

    scanline_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench model: contents of the bank being written and the bank displayed.
    logic [4:0] wbank [256];
    logic [4:0] rbank [256];
    logic       m_full;
    logic [4:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.true_line   = 10'd0;
        bus.true_column = 10'd600;
    endtask

    task automatic model_swap();
        logic [4:0] t;
        for (int i = 0; i < 256; i++) begin
            t        = wbank[i];
            wbank[i] = rbank[i];
            rbank[i] = t;
        end
        m_full = 1'b0;
    endtask

    task automatic wr(input int col, input logic [4:0] pix);
        bus.wr_valid = 1'b1;
        bus.wr_col   = 8'(col);
        bus.wr_pixel = pix;
        tick();
        bus.wr_valid = 1'b0;
        if (!m_full) wbank[col] = pix;
    endtask

    task automatic line_done();
        bus.wr_line_done = 1'b1;
        tick();
        bus.wr_line_done = 1'b0;
        m_full = 1'b1;
    endtask

    task automatic hit_swap_col(input int line);
        bus.true_line   = 10'(line);
        bus.true_column = 10'd512;
        tick();
        idle();
    endtask

    task automatic scan(input int line, input int ncols);
        for (int c = 0; c < ncols; c++) begin
            bus.true_line   = 10'(line);
            bus.true_column = 10'(c);
            if (c < 512 && line < 480) exp_q.push_back(rbank[c / 2]);
            else                       exp_q.push_back(5'd0);
            tick();
            check("pixel_out", {27'd0, bus.pixel_out}, {27'd0, exp_q.pop_front()});
        end
        idle();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        m_full = 1'b0;
        reset  = 1'b1;
        bus.wr_valid     = 1'b0;
        bus.wr_col       = 8'd0;
        bus.wr_pixel     = 5'd0;
        bus.wr_line_done = 1'b0;
        idle();
        repeat (2) tick();

        // Reset state
        check("rst_ready",    {31'd0, bus.wr_ready},     32'd1);
        check("rst_pixel",    {27'd0, bus.pixel_out},    32'd0);
        check("rst_underrun", {24'd0, bus.underrun_cnt}, 32'd0);
        check("rst_wsel",     {31'd0, dut.wsel},         32'd0);
        reset = 1'b0;
        tick();

        // Basic fill: pixel = col[4:0], line done on line 1, swap at (1,512)
        for (int c = 0; c < 256; c++) wr(c, 5'(c));
        bus.true_line   = 10'd1;
        bus.true_column = 10'd100;
        line_done();
        check("ready_after_done", {31'd0, bus.wr_ready}, 32'd0);
        hit_swap_col(1);
        model_swap();
        check("ready_after_swap", {31'd0, bus.wr_ready}, 32'd1);
        check("wsel_after_swap",  {31'd0, dut.wsel},     32'd1);
        scan(2, 800);
        scan(3, 512);

        // Underrun: no line done before (3,512)
        hit_swap_col(3);
        check("underrun_one",  {24'd0, bus.underrun_cnt}, 32'd1);
        check("underrun_wsel", {31'd0, dut.wsel},         32'd1);
        scan(4, 512);
        scan(5, 512);

        // Fill a second pattern, then try to write during FULL
        for (int c = 0; c < 256; c++) wr(c, 5'(c * 3));
        line_done();
        check("ready_full2", {31'd0, bus.wr_ready}, 32'd0);
        wr(0, 5'h0A);
        check("ready_lockout", {31'd0, bus.wr_ready}, 32'd0);

        // Blanking lines and suppressed swap below the visible frame
        scan(480, 16);
        hit_swap_col(481);
        check("vblank_wsel",     {31'd0, dut.wsel},         32'd1);
        check("vblank_ready",    {31'd0, bus.wr_ready},     32'd0);
        check("vblank_underrun", {24'd0, bus.underrun_cnt}, 32'd1);

        // Real swap: the locked-out write must not appear
        hit_swap_col(5);
        model_swap();
        check("swap2_wsel",  {31'd0, dut.wsel},     32'd0);
        check("swap2_ready", {31'd0, bus.wr_ready}, 32'd1);
        scan(6, 512);

        // Simultaneous swap event, line done and final write
        for (int c = 0; c < 255; c++) wr(c, 5'(c + 7));
        bus.true_line    = 10'd7;
        bus.true_column  = 10'd512;
        bus.wr_valid     = 1'b1;
        bus.wr_col       = 8'd255;
        bus.wr_pixel     = 5'h1F;
        bus.wr_line_done = 1'b1;
        tick();
        bus.wr_valid     = 1'b0;
        bus.wr_line_done = 1'b0;
        idle();
        wbank[255] = 5'h1F;
        model_swap();
        check("simul_wsel",     {31'd0, dut.wsel},         32'd1);
        check("simul_ready",    {31'd0, bus.wr_ready},     32'd1);
        check("simul_underrun", {24'd0, bus.underrun_cnt}, 32'd1);
        scan(8, 512);

        // Saturation of the underrun counter
        bus.true_line   = 10'd9;
        bus.true_column = 10'd512;
        repeat (300) tick();
        idle();
        check("underrun_sat", {24'd0, bus.underrun_cnt}, 32'd255);

        // Asynchronous reset while FULL
        wr(0, 5'd1);
        line_done();
        check("pre_reset_ready", {31'd0, bus.wr_ready}, 32'd0);
        bus.true_line   = 10'd8;
        bus.true_column = 10'd2;
        tick();
        check("pre_reset_pixel", {27'd0, bus.pixel_out}, {27'd0, rbank[1]});
        #2 reset = 1'b1;
        #1;
        check("async_ready",    {31'd0, bus.wr_ready},     32'd1);
        check("async_pixel",    {27'd0, bus.pixel_out},    32'd0);
        check("async_underrun", {24'd0, bus.underrun_cnt}, 32'd0);
        check("async_wsel",     {31'd0, dut.wsel},         32'd0);
        tick();
        reset = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scanline_buffer.md
# scanline_buffer

Ping-pong line store between the pixel processor and the palette/colour lookup. Captures one 256-pixel line of 5-bit tile pixels (palette select + colour index) from the pixel processor, then replays it twice on the 512×480 VGA raster (2× horizontal and vertical scan doubling). This decouples pixel-processor render timing from the VGA beam position. Rendering of line n+1 may run at any pace while line n is displayed.

## Interface
Parameters:
- H_ACTIVE, 512: visible VGA columns; output forced to 0 at or beyond this column.
- V_ACTIVE, 480: visible VGA lines; output forced to 0 and swaps suppressed at or beyond this line.
- SWAP_COL, 512: VGA column on which the end-of-line swap check is made (first blanking column).

Ports:
- clk  in  1  pixel clock (20 MHz PLL output).
- reset  in  1  asynchronous, active-high; all state listed below returns to reset values immediately.
- wr_valid  in  1  write strobe for wr_pixel at wr_col.
- wr_col  in  8  line position 0..255 (any order permitted).
- wr_pixel  in  5  {palette[1:0], colour[2:0]} from the pixel processor.
- wr_line_done  in  1  single-cycle pulse: write bank holds a complete line.
- wr_ready  out  1  write bank accepting pixels.
- true_line  in  10  VGA line counter.
- true_column  in  10  VGA column counter.
- pixel_out  out  5  pixel for the current beam position, feeds palette lookup.
- underrun_cnt  out  8  saturating count of missed swaps.

## Operation
- Storage: two banks, 256×5 each (iCE40 block RAM or LUT RAM). The bank select bit `wsel` names the write bank; the read bank is `!wsel`. RAM contents are not reset.
- Write FSM has two states:
  - FILL: wr_ready=1. wr_valid writes wr_pixel to bank[wsel][wr_col]. wr_line_done moves the FSM to FULL.
  - FULL: wr_ready=0. wr_valid and wr_line_done are ignored; no RAM write occurs.
- Swap event: true_column==SWAP_COL && true_line[0]==1 && true_line<V_ACTIVE. This is the end of the second (odd) display of a line.
  - If the state is FULL: toggle wsel and go to FILL.
  - If the state is FILL with no wr_line_done this cycle: no toggle, and underrun_cnt increments, saturating at 255. The old read line is displayed again.
  - If the state is FILL with wr_line_done in the same cycle: the line completes and the swap happens. Toggle wsel and remain in FILL. A wr_valid write in that cycle lands in the outgoing write bank before the toggle.
- Read path:
  - active = true_column<H_ACTIVE && true_line<V_ACTIVE.
  - pixel_out <= active ? bank[!wsel][true_column[8:1]] : 0.
  - true_column[0] and true_line[0] are ignored for addressing. Each stored pixel therefore covers a 2×2 block of VGA pixels.
- Reset values: wsel=0, state FILL, wr_ready=1, pixel_out=0, underrun_cnt=0.
- Reset mid-line discards any partial fill. The first read line after reset is undefined RAM content. Downstream tolerates this for one line pair.

## Timing
- Write: a pixel written on edge k is readable from the read side only after a swap. There is no same-bank read/write hazard.
- Read latency: pixel_out is valid 1 clk after true_line/true_column present. It is registered, with no combinational path from the counters to the output.
- wr_ready is a registered state decode. It falls the cycle after an accepted wr_line_done and rises the cycle after a swap.
- A swap on edge k takes effect for reads sampled on edge k+1 onward. SWAP_COL is in blanking, so no visible pixel mixes banks.
- Minimum line budget: 2 VGA lines per rendered line. underrun_cnt reports any overrun of that budget.

## Test plan
- Basic fill/replay: write pixel = col[4:0] for cols 0..255, pulse wr_line_done on line 1, then scan lines 2–3. Required: pixel_out at column 2c and 2c+1 = c[4:0] on both lines, 1-cycle latency; wr_ready low until the swap at (line 1, col 512), high after it.
- Blanking: with valid data loaded, scan columns 512..799 and line 480. Required: pixel_out=0. A swap at (line 481, SWAP_COL) is suppressed, with wsel unchanged.
- Underrun: give no wr_line_done before (line 3, col 512). Required: wsel unchanged, lines 4–5 repeat the lines 2–3 data, underrun_cnt=1. Force 300 misses: underrun_cnt=255.
- Simultaneous events: wr_line_done and wr_valid(col 255, 5'h1F) in the same cycle as the swap event. Required: swap occurs, col 255 reads 5'h1F on the next line pair, FSM in FILL, underrun_cnt unchanged.
- FULL lockout: after wr_line_done, drive wr_valid col 0=5'h0A before the swap. Required: the displayed line after the swap shows the original col 0 value.
- Async reset mid-fill: assert reset between clock edges with the FSM in FULL. Required: immediately wr_ready=1, pixel_out=0, underrun_cnt=0, wsel=0, with no clock edge needed.
